// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART host command decoder and instruction memory loader
//
// Decodes host command bytes from the UART RX core (LOAD/RUN/STOP/STEP), streams
// little-endian instruction words into instruction memory and drives the MIPS enable.
//
// Ports:
//   clk, rst      system clock (rising edge), synchronous active-high reset
//   rx_data       received byte, valid while rx_done=1
//   rx_done       one-cycle strobe per received byte
//   imem_we       instruction memory write strobe, one cycle per word
//   imem_addr     word address for imem_we
//   imem_wdata    assembled word for imem_we
//   mips_enable   pipeline clock enable
//   mips_rst      one-cycle pipeline reset pulse at the start of a LOAD
//   busy          high while a LOAD is in progress
//   cmd_err       one-cycle pulse on an unknown command or a LOAD timeout

module uart_program_loader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              mips_enable,
  output logic              mips_rst,
  output logic              busy,
  output logic              cmd_err
);

  localparam int BYTES    = DATA_W / 8;
  localparam int BIDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int TIMER_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BIDX_W-1:0]  LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GET_CNT  = 2'd1;
  localparam logic [1:0] GET_WORD = 2'd2;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STOP = 8'h03;
  localparam logic [7:0] CMD_STEP = 8'h04;

  logic [1:0]         state;
  logic [7:0]         wordsLeft;
  logic [ADDR_W-1:0]  wordIdx;
  logic [BIDX_W-1:0]  byteIdx;
  logic [TIMER_W-1:0] timer;
  logic [DATA_W-1:0]  wordBuf;
  logic [DATA_W-1:0]  nextWord;
  logic               stepOne;

  // Bytes shift in from the top so the first byte of a word lands in bits [7:0].
  generate
    if (DATA_W > 8) begin : g_shift
      assign nextWord = {rx_data, wordBuf[DATA_W-1:8]};
    end else begin : g_single
      assign nextWord = rx_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wordsLeft   <= '0;
      wordIdx     <= '0;
      byteIdx     <= '0;
      timer       <= '0;
      wordBuf     <= '0;
      stepOne     <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      mips_enable <= 1'b0;
      mips_rst    <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      imem_we  <= 1'b0;
      mips_rst <= 1'b0;
      cmd_err  <= 1'b0;

      // A STEP enable lasts one cycle; a command decoded this same cycle overrides it below.
      if (stepOne) begin
        mips_enable <= 1'b0;
        stepOne     <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_done) begin
            case (rx_data)
              CMD_LOAD: begin
                state       <= GET_CNT;
                busy        <= 1'b1;
                mips_rst    <= 1'b1;
                mips_enable <= 1'b0;
                stepOne     <= 1'b0;
                timer       <= '0;
              end
              CMD_RUN:  mips_enable <= 1'b1;
              CMD_STOP: mips_enable <= 1'b0;
              CMD_STEP: begin
                mips_enable <= 1'b1;
                stepOne     <= 1'b1;
              end
              default:  cmd_err <= 1'b1;
            endcase
          end
        end
        GET_CNT: begin
          if (rx_done) begin
            timer <= '0;
            if (rx_data == 8'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              wordsLeft <= rx_data;
              wordIdx   <= '0;
              byteIdx   <= '0;
              state     <= GET_WORD;
            end
          end
        end
        GET_WORD: begin
          if (rx_done) begin
            timer   <= '0;
            wordBuf <= nextWord;
            if (byteIdx == LAST_BYTE) begin
              byteIdx    <= '0;
              imem_we    <= 1'b1;
              imem_addr  <= wordIdx;
              imem_wdata <= nextWord;
              wordIdx    <= wordIdx + 1'b1;
              wordsLeft  <= wordsLeft - 8'd1;
              if (wordsLeft == 8'd1) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              byteIdx <= byteIdx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Inter-byte watchdog: abort the LOAD, keeping words already written.
      if ((state == GET_CNT || state == GET_WORD) && !rx_done) begin
        if (timer == TIMER_MAX) begin
          cmd_err <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
          byteIdx <= '0;
          timer   <= '0;
        end else begin
          timer <= timer + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - scoreboard bench for uart_program_loader
module tb_uart_program_loader;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 100;
  localparam int NB      = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_done = 1'b0;
  logic imem_we, mips_enable, mips_rst, busy, cmd_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  uart_program_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .mips_enable(mips_enable), .mips_rst(mips_rst), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                c;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t expWr[$];
  int  expErr[$];
  int  expRst[$];
  bit  enSched[int];
  bit  busySched[int];
  bit  curEn = 1'b0;
  bit  curBusy = 1'b0;
  bit  monOn = 1'b0;

  // Protocol-level reference model state
  bit         inLoad = 1'b0;
  bit         needCnt = 1'b0;
  int         wordsLeft = 0;
  int         wordAddr = 0;
  logic [7:0] pend[$];
  int         lastE = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkPulse(input string name, input logic seen, inout int q[$]);
    while (q.size() > 0 && q[0] < cyc) begin
      check({name, " missing"}, 64'(0), 64'(1));
      void'(q.pop_front());
    end
    if (seen) begin
      if (q.size() > 0 && q[0] == cyc) begin
        check(name, 64'(seen), 64'(1));
        void'(q.pop_front());
      end else begin
        check({name, " unexpected"}, 64'(seen), 64'(0));
      end
    end
  endtask

  always @(negedge clk) begin
    if (monOn) begin
      if (enSched.exists(cyc)) curEn = enSched[cyc];
      if (busySched.exists(cyc)) curBusy = busySched[cyc];
      check("mips_enable", 64'(mips_enable), 64'(curEn));
      check("busy", 64'(busy), 64'(curBusy));
      while (expWr.size() > 0 && expWr[0].c < cyc) begin
        check("imem_we missing", 64'(0), 64'(1));
        void'(expWr.pop_front());
      end
      if (imem_we) begin
        if (expWr.size() > 0 && expWr[0].c == cyc) begin
          wr_t w;
          w = expWr.pop_front();
          check("imem_addr", 64'(imem_addr), 64'(w.a));
          check("imem_wdata", 64'(imem_wdata), 64'(w.d));
        end else begin
          check("imem_we unexpected", 64'(imem_we), 64'(0));
        end
      end
      checkPulse("cmd_err", cmd_err, expErr);
      checkPulse("mips_rst", mips_rst, expRst);
    end
  end

  task automatic model(input logic [7:0] b, input int e);
    logic [DATA_W-1:0] word;
    if (!inLoad) begin
      case (b)
        8'h01: begin
          inLoad = 1'b1; needCnt = 1'b1;
          expRst.push_back(e);
          enSched[e] = 1'b0;
          busySched[e] = 1'b1;
        end
        8'h02: enSched[e] = 1'b1;
        8'h03: enSched[e] = 1'b0;
        8'h04: begin enSched[e] = 1'b1; enSched[e+1] = 1'b0; end
        default: expErr.push_back(e);
      endcase
    end else if (needCnt) begin
      if (b == 8'h00) begin
        inLoad = 1'b0;
        busySched[e] = 1'b0;
      end else begin
        needCnt = 1'b0; wordsLeft = int'(b); wordAddr = 0; pend.delete();
      end
    end else begin
      pend.push_back(b);
      if (pend.size() == NB) begin
        word = '0;
        for (int i = 0; i < NB; i++) word = word | (DATA_W'(pend[i]) << (8 * i));
        expWr.push_back('{c: e, a: ADDR_W'(wordAddr), d: word});
        wordAddr++;
        pend.delete();
        wordsLeft--;
        if (wordsLeft == 0) begin
          inLoad = 1'b0;
          busySched[e] = 1'b0;
        end
      end
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int e;
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    e = cyc + 1;
    lastE = e;
    model(b, e);
  endtask

  task automatic idle(input int n);
    if (inLoad && n >= TIMEOUT) begin
      expErr.push_back(lastE + TIMEOUT);
      busySched[lastE + TIMEOUT] = 1'b0;
      inLoad = 1'b0;
      needCnt = 1'b0;
      pend.delete();
    end
    repeat (n) begin
      @(negedge clk);
      rx_done = 1'b0;
    end
  endtask

  task automatic sendSeq(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) begin
      sendByte(bytes[i]);
      idle(gap);
    end
  endtask

  task automatic doReset();
    int e;
    @(negedge clk);
    rst = 1'b1;
    rx_done = 1'b0;
    e = cyc + 1;
    inLoad = 1'b0; needCnt = 1'b0; pend.delete();
    enSched[e] = 1'b0;
    busySched[e] = 1'b0;
    while (expWr.size() > 0 && expWr[$].c >= e) void'(expWr.pop_back());
    while (expErr.size() > 0 && expErr[$] >= e) void'(expErr.pop_back());
    while (expRst.size() > 0 && expRst[$] >= e) void'(expRst.pop_back());
    @(negedge clk);
    check("rst imem_we", 64'(imem_we), 64'(0));
    check("rst mips_enable", 64'(mips_enable), 64'(0));
    check("rst mips_rst", 64'(mips_rst), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst cmd_err", 64'(cmd_err), 64'(0));
    check("rst imem_addr", 64'(imem_addr), 64'(0));
    check("rst imem_wdata", 64'(imem_wdata), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] seq[$];
    repeat (3) @(negedge clk);
    check("reset imem_we", 64'(imem_we), 64'(0));
    check("reset mips_enable", 64'(mips_enable), 64'(0));
    check("reset mips_rst", 64'(mips_rst), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset cmd_err", 64'(cmd_err), 64'(0));
    check("reset imem_addr", 64'(imem_addr), 64'(0));
    check("reset imem_wdata", 64'(imem_wdata), 64'(0));
    rst = 1'b0;
    monOn = 1'b1;

    // LOAD of two words
    seq = '{8'h01, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    sendSeq(seq, 1);
    idle(5);
    // empty LOAD then RUN
    seq = '{8'h01, 8'h00, 8'h02};
    sendSeq(seq, 2);
    idle(3);
    sendByte(8'h03); idle(3);
    // RUN held for 50 cycles then STOP
    sendByte(8'h02); idle(50);
    sendByte(8'h03); idle(3);
    // STEP from idle, then STEP while running
    sendByte(8'h04); idle(4);
    sendByte(8'h02); idle(3);
    sendByte(8'h04); idle(4);
    // unknown command
    sendByte(8'h7F); idle(3);
    // timeout mid-word, then RUN decoded normally
    seq = '{8'h01, 8'h01, 8'hAA};
    sendSeq(seq, 1);
    idle(TIMEOUT + 10);
    sendByte(8'h02); idle(3);
    sendByte(8'h03); idle(3);
    // reset mid-word
    seq = '{8'h01, 8'h02, 8'h11, 8'h22};
    sendSeq(seq, 1);
    doReset();
    idle(2);
    // back-to-back strobes overlapping mips_rst and imem_we
    seq = '{8'h01, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h04, 8'h02};
    sendSeq(seq, 0);
    idle(3);
    sendByte(8'h03); idle(3);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        int n;
        n = $urandom_range(0, 4);
        sendByte(8'h01); idle($urandom_range(0, 3));
        sendByte(8'(n)); idle($urandom_range(0, 3));
        for (int k = 0; k < n * NB; k++) begin
          sendByte(8'($urandom_range(0, 255)));
          idle($urandom_range(0, 3));
        end
      end else if (op <= 6) begin
        sendByte(8'($urandom_range(2, 4))); idle($urandom_range(0, 3));
      end else if (op <= 8) begin
        sendByte(8'($urandom_range(5, 255))); idle($urandom_range(0, 3));
      end else begin
        sendByte(8'h01); idle(1);
        sendByte(8'h02); idle(1);
        for (int k = 0; k < $urandom_range(0, NB + 2); k++) begin
          sendByte(8'($urandom_range(0, 255))); idle(1);
        end
        idle(TIMEOUT + 2);
      end
    end
    idle(TIMEOUT + 5);

    check("drain imem_we", 64'(expWr.size()), 64'(0));
    check("drain cmd_err", 64'(expErr.size()), 64'(0));
    check("drain mips_rst", 64'(expRst.size()), 64'(0));
    monOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
